dmem_arbiter: RTL and testbench

//  Two-port arbiter sharing the single-port data memory (write/read/addr/din/dout, combinational read)

---
 rtl/dmem_arbiter_pkg.sv | 23 ++
 rtl/dmem_arbiter_rr2_burst_arb.sv | 68 ++++++
 rtl/dmem_arbiter.sv | 113 +++++++++++
 tb/tb_dmem_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: port indices, access encoding
// and default geometry.
package dmem_arbiter_pkg;

    localparam int DW_DEF        = 32;
    localparam int AW_DEF        = 10;
    localparam int BURST_LEN_DEF = 4;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_DBG  = 1'b1
    } port_e;

    typedef enum logic {
        ACC_RD = 1'b0,
        ACC_WR = 1'b1
    } acc_e;

    function automatic port_e other_port(input port_e p);
        return (p == PORT_CORE) ? PORT_DBG : PORT_CORE;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr2_burst_arb.sv
// Two-requester round-robin arbiter with a bounded burst allowance.
// Produces a one-hot grant combinationally and tracks the current owner's streak.
module dmem_arbiter_rr2_burst_arb
    import dmem_arbiter_pkg::*;
#(
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    localparam int            CW      = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(BURST_LEN - 1);

    port_e         last_owner_q, last_owner_d;
    logic          streak_q, streak_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic          keep_owner;
    port_e         winner;

    // The burst allowance only covers back-to-back grants: after an idle cycle
    // contention goes to the port that did not own the bus last, which is why
    // port 0 wins the first contention out of reset.
    always_comb begin
        gnt        = 2'b00;
        winner     = last_owner_q;
        keep_owner = streak_q && req[last_owner_q] && (burst_cnt_q < CNT_MAX);
        case (req)
            2'b01:   winner = PORT_CORE;
            2'b10:   winner = PORT_DBG;
            2'b11:   winner = keep_owner ? last_owner_q : other_port(last_owner_q);
            default: winner = last_owner_q;
        endcase
        if (reset && (req != 2'b00)) begin
            gnt[winner] = 1'b1;
        end
    end

    always_comb begin
        last_owner_d = last_owner_q;
        streak_d     = 1'b0;
        burst_cnt_d  = '0;
        if (gnt != 2'b00) begin
            streak_d = 1'b1;
            if (winner == last_owner_q) begin
                burst_cnt_d = (burst_cnt_q == CNT_MAX) ? burst_cnt_q : burst_cnt_q + CW'(1);
            end else begin
                last_owner_d = winner;
                burst_cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner_q <= PORT_DBG;
            streak_q     <= 1'b0;
            burst_cnt_q  <= '0;
        end else begin
            last_owner_q <= last_owner_d;
            streak_q     <= streak_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the core LSU (port 0) and the
// debug/DMA loader (port 1); one access per cycle, registered acks and read data.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int AW        = AW_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [31:0]   addr0,
    input  logic [31:0]   addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          ack0,
    output logic          ack1,
    output logic          err0,
    output logic          err1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_write,
    output logic          mem_read,
    output logic [31:0]   mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    logic [1:0]    req;
    logic [1:0]    gnt;
    logic [1:0]    oor;
    port_e         sel;
    acc_e          sel_acc;
    logic          sel_oor;
    logic [31:0]   sel_addr;
    logic [DW-1:0] sel_wdata;

    logic [1:0]    ack_q, ack_d;
    logic [1:0]    err_q, err_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    assign req = {req1, req0};

    dmem_arbiter_rr2_burst_arb #(
        .BURST_LEN(BURST_LEN)
    ) u_arb (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .gnt  (gnt)
    );

    // Any set bit above the implemented address range would alias onto a valid
    // word, so such accesses are granted but never reach the memory.
    always_comb begin
        oor[0]    = |addr0[31:AW];
        oor[1]    = |addr1[31:AW];
        sel       = gnt[1] ? PORT_DBG : PORT_CORE;
        sel_acc   = (sel == PORT_DBG) ? acc_e'(we1) : acc_e'(we0);
        sel_addr  = (sel == PORT_DBG) ? addr1 : addr0;
        sel_wdata = (sel == PORT_DBG) ? wdata1 : wdata0;
        sel_oor   = (sel == PORT_DBG) ? oor[1] : oor[0];

        mem_write = 1'b0;
        mem_read  = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        if ((gnt != 2'b00) && !sel_oor) begin
            mem_write = (sel_acc == ACC_WR);
            mem_read  = (sel_acc == ACC_RD);
            mem_addr  = {{(32-AW){1'b0}}, sel_addr[AW-1:0]};
            mem_din   = sel_wdata;
        end
    end

    always_comb begin
        ack_d    = gnt;
        err_d    = gnt & oor;
        rdata0_d = (gnt[0] && !oor[0] && !we0) ? mem_dout : rdata0_q;
        rdata1_d = (gnt[1] && !oor[1] && !we1) ? mem_dout : rdata1_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_q    <= '0;
            err_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign gnt0   = gnt[0];
    assign gnt1   = gnt[1];
    assign ack0   = ack_q[0];
    assign ack1   = ack_q[1];
    assign err0   = err_q[0];
    assign err1   = err_q[1];
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural memory, scoreboard monitor
// with per-port expected queues, and one task per scenario.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int DW        = DW_DEF;
    localparam int AW        = AW_DEF;
    localparam int BURST_LEN = BURST_LEN_DEF;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1;
    logic [31:0]   addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, ack0, ack1, err0, err1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_write, mem_read;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_din, mem_dout;

    logic [DW-1:0] tb_mem  [2**AW];
    logic [DW-1:0] ref_mem [2**AW];
    logic [DW-1:0] rdata_m [2];
    logic [DW:0]   exp_q0[$];
    logic [DW:0]   exp_q1[$];
    int            n_checks = 0;
    int            n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) tb_mem[mem_addr[AW-1:0]] <= mem_din;
    end
    assign mem_dout = tb_mem[mem_addr[AW-1:0]];

    dmem_arbiter #(.DW(DW), .AW(AW), .BURST_LEN(BURST_LEN)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Scoreboard: responses are checked before the current cycle's grant is recorded.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_q0.delete();
                exp_q1.delete();
                rdata_m[0] = '0;
                rdata_m[1] = '0;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    logic          a;
                    logic          have;
                    logic [DW:0]   obs;
                    logic [DW:0]   exp;
                    a    = (p == 1) ? ack1 : ack0;
                    obs  = (p == 1) ? {err1, rdata1} : {err0, rdata0};
                    have = (p == 1) ? (exp_q1.size() > 0) : (exp_q0.size() > 0);
                    if (a) begin
                        n_checks++;
                        if (!have) begin
                            n_errors++;
                            $display("FAIL sb_unexpected_ack port%0d: got ack=1, expected no ack", p);
                        end else begin
                            exp = (p == 1) ? exp_q1.pop_front() : exp_q0.pop_front();
                            if (obs !== exp) begin
                                n_errors++;
                                $display("FAIL sb_resp port%0d: got err=%0b rdata=%h, expected err=%0b rdata=%h",
                                         p, obs[DW], obs[DW-1:0], exp[DW], exp[DW-1:0]);
                            end
                        end
                    end else if (have) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL sb_missing_ack port%0d: got ack=0, expected ack=1", p);
                        if (p == 1) exp_q1.delete(); else exp_q0.delete();
                    end
                end

                n_checks++;
                if (gnt0 && gnt1) begin
                    n_errors++;
                    $display("FAIL gnt_onehot: got gnt0=1 gnt1=1, expected at most one");
                end else if (gnt0 || gnt1) begin
                    int            p;
                    logic          w;
                    logic          oor;
                    logic [31:0]   a;
                    logic [DW-1:0] d;
                    p   = gnt1 ? 1 : 0;
                    w   = (p == 1) ? we1 : we0;
                    a   = (p == 1) ? addr1 : addr0;
                    d   = (p == 1) ? wdata1 : wdata0;
                    oor = |a[31:AW];
                    if (mem_write !== (!oor && w) || mem_read !== (!oor && !w)) begin
                        n_errors++;
                        $display("FAIL mem_ctl port%0d: got wr=%0b rd=%0b, expected wr=%0b rd=%0b",
                                 p, mem_write, mem_read, !oor && w, !oor && !w);
                    end
                    if (!oor) begin
                        n_checks++;
                        if (mem_addr !== {{(32-AW){1'b0}}, a[AW-1:0]} || (w && mem_din !== d)) begin
                            n_errors++;
                            $display("FAIL mem_bus port%0d: got addr=%h din=%h, expected addr=%h din=%h",
                                     p, mem_addr, mem_din, {{(32-AW){1'b0}}, a[AW-1:0]}, d);
                        end
                        if (w) ref_mem[a[AW-1:0]] = d;
                        else   rdata_m[p] = ref_mem[a[AW-1:0]];
                    end
                    if (p == 1) exp_q1.push_back({oor, rdata_m[p]});
                    else        exp_q0.push_back({oor, rdata_m[p]});
                end else if (mem_write !== 1'b0 || mem_read !== 1'b0 || mem_addr !== '0 || mem_din !== '0) begin
                    n_errors++;
                    $display("FAIL mem_idle: got wr=%0b rd=%0b addr=%h din=%h, expected all 0",
                             mem_write, mem_read, mem_addr, mem_din);
                end
            end
        end
    endtask

    task automatic drive(input int p, input logic r, input logic w, input logic [31:0] a,
                         input logic [DW-1:0] d);
        if (p == 1) begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    // Returns one time unit after the edge that makes the ack visible.
    task automatic access(input int p, input logic w, input logic [31:0] a, input logic [DW-1:0] d);
        int waited;
        waited = 0;
        @(posedge clk); #1;
        drive(p, 1'b1, w, a, d);
        @(negedge clk);
        while (!((p == 1) ? gnt1 : gnt0) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            n_checks++;
            n_errors++;
            $display("FAIL access_timeout port%0d: got no grant in 20 cycles, expected grant", p);
        end
        @(posedge clk); #1;
        drive(p, 1'b0, 1'b0, 32'h0, '0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, '0);
        drive(1, 1'b0, 1'b0, 32'h0, '0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({gnt0, gnt1, ack0, ack1, err0, err1, mem_write, mem_read} !== 8'h00 ||
            rdata0 !== '0 || rdata1 !== '0 || mem_addr !== '0 || mem_din !== '0) begin
            n_errors++;
            $display("FAIL reset_idle: got gnt=%0b%0b ack=%0b%0b rdata0=%h, expected all 0",
                     gnt0, gnt1, ack0, ack1, rdata0);
        end
        reset = 1'b1;
        access(0, 1'b1, 32'd7, 32'h0000_0077);
        access(0, 1'b0, 32'd7, '0);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'd7, '0);
        #1;
        n_checks++;
        if (gnt0 !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_pre_gnt: got gnt0=%0b, expected 1", gnt0);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (gnt0 !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0 || rdata0 !== '0 || mem_read !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid: got gnt0=%0b ack0=%0b rdata0=%h mem_read=%0b, expected 0",
                     gnt0, ack0, rdata0, mem_read);
        end
        @(posedge clk); #1;
        n_checks++;
        if (ack0 !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_dropped_ack: got ack0=%0b, expected 0", ack0);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (gnt0 !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release_gnt: got gnt0=%0b, expected 1", gnt0);
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, '0);
        n_checks++;
        if (ack0 !== 1'b1 || rdata0 !== 32'h0000_0077) begin
            n_errors++;
            $display("FAIL reset_release_ack: got ack0=%0b rdata0=%h, expected 1 00000077", ack0, rdata0);
        end
    endtask

    task automatic test_single_port();
        access(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
        n_checks++;
        if (ack0 !== 1'b1 || err0 !== 1'b0 || rdata0 !== 32'h0000_0077) begin
            n_errors++;
            $display("FAIL single_write: got ack0=%0b err0=%0b rdata0=%h, expected 1 0 00000077",
                     ack0, err0, rdata0);
        end
        access(0, 1'b0, 32'd5, '0);
        n_checks++;
        if (ack0 !== 1'b1 || err0 !== 1'b0 || rdata0 !== 32'hDEAD_BEEF) begin
            n_errors++;
            $display("FAIL single_read: got ack0=%0b err0=%0b rdata0=%h, expected 1 0 deadbeef",
                     ack0, err0, rdata0);
        end
    endtask

    task automatic test_contention();
        logic [11:0] seq;
        seq = 12'b0000_1111_0000;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        drive(0, 1'b1, 1'b1, 32'd20, 32'hA0A0_0000);
        drive(1, 1'b1, 1'b1, 32'd21, 32'hB1B1_0000);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_checks++;
            if (gnt0 !== !seq[i] || gnt1 !== seq[i]) begin
                n_errors++;
                $display("FAIL contention_c%0d: got gnt0=%0b gnt1=%0b, expected gnt0=%0b gnt1=%0b",
                         i, gnt0, gnt1, !seq[i], seq[i]);
            end
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, '0);
        drive(1, 1'b0, 1'b0, 32'h0, '0);
    endtask

    task automatic test_simultaneous();
        access(1, 1'b0, 32'd5, '0);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'd5, '0);
        drive(1, 1'b1, 1'b0, 32'd20, '0);
        @(negedge clk);
        n_checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            n_errors++;
            $display("FAIL simul_first: got gnt0=%0b gnt1=%0b, expected 1 0", gnt0, gnt1);
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, '0);
        @(negedge clk);
        n_checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin
            n_errors++;
            $display("FAIL simul_second: got gnt0=%0b gnt1=%0b, expected 0 1", gnt0, gnt1);
        end
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 32'h0, '0);
        n_checks++;
        if (ack1 !== 1'b1 || rdata1 !== 32'hA0A0_0000) begin
            n_errors++;
            $display("FAIL simul_rdata1: got ack1=%0b rdata1=%h, expected 1 a0a00000", ack1, rdata1);
        end
    endtask

    task automatic test_out_of_range();
        access(1, 1'b0, 32'd7, '0);
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 32'h0000_0400, '0);
        @(negedge clk);
        n_checks++;
        if (gnt1 !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            n_errors++;
            $display("FAIL oor_mem: got gnt1=%0b mem_read=%0b mem_write=%0b, expected 1 0 0",
                     gnt1, mem_read, mem_write);
        end
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 32'h0, '0);
        n_checks++;
        if (ack1 !== 1'b1 || err1 !== 1'b1 || rdata1 !== 32'h0000_0077) begin
            n_errors++;
            $display("FAIL oor_resp: got ack1=%0b err1=%0b rdata1=%h, expected 1 1 00000077",
                     ack1, err1, rdata1);
        end
        access(0, 1'b1, 32'h0000_0405, 32'h5555_AAAA);
        n_checks++;
        if (err0 !== 1'b1) begin
            n_errors++;
            $display("FAIL oor_write_err: got err0=%0b, expected 1", err0);
        end
        access(0, 1'b0, 32'd5, '0);
        n_checks++;
        if (err0 !== 1'b0 || rdata0 !== 32'hDEAD_BEEF) begin
            n_errors++;
            $display("FAIL oor_no_alias: got err0=%0b rdata0=%h, expected 0 deadbeef", err0, rdata0);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] bb_exp [3];
        bb_exp[0] = 32'h11;
        bb_exp[1] = 32'h22;
        bb_exp[2] = 32'h33;
        for (int i = 0; i < 3; i++) access(0, 1'b1, 32'(i + 1), bb_exp[i]);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'd1, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (gnt0 !== 1'b1) begin
                n_errors++;
                $display("FAIL b2b_gnt%0d: got gnt0=%0b, expected 1", i, gnt0);
            end
            @(posedge clk); #1;
            if (i < 2) drive(0, 1'b1, 1'b0, 32'(i + 2), '0);
            else       drive(0, 1'b0, 1'b0, 32'h0, '0);
            n_checks++;
            if (ack0 !== 1'b1 || rdata0 !== bb_exp[i]) begin
                n_errors++;
                $display("FAIL b2b_ack%0d: got ack0=%0b rdata0=%h, expected 1 %h", i, ack0, rdata0, bb_exp[i]);
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (ack0 !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_end: got ack0=%0b, expected 0", ack0);
        end
    endtask

    initial begin
        rdata_m[0] = '0;
        rdata_m[1] = '0;
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, '0);
        drive(1, 1'b0, 1'b0, 32'h0, '0);
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: got no completion by 200000, expected finish");
                $fatal(1, "watchdog expired");
            end
        join_none
        test_reset();
        test_single_port();
        test_contention();
        test_simultaneous();
        test_out_of_range();
        test_back_to_back();
        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
